// File: rtl/mult_pipe_pkg.sv
// ---------------------------------------------------------------------------
// mult_pipe_pkg
// Shared definitions for the five-stage RV32M multiplier pipeline:
//   - DATA_W / ADDR_W     : operand and register-address widths
//   - MULT_STAGES         : number of pipeline stages (M1..M5)
//   - EXT_W / PP_LO_W ... : widths of the extended operands and partial products
//   - mulOp_e             : RV32M multiply operation encodings
//   - signedA / signedB   : which operand is sign-extended for a given op
// ---------------------------------------------------------------------------
package mult_pipe_pkg;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 5;
    localparam int MULT_STAGES = 5;

    // Operands are widened by one bit so signed and unsigned forms share one
    // signed multiplier; each 33-bit operand is split into a 17-bit unsigned
    // low half and a 16-bit signed high half.
    localparam int EXT_W   = DATA_W + 1;
    localparam int LO_W    = 17;
    localparam int HI_W    = EXT_W - LO_W;
    localparam int PP_W    = LO_W + LO_W;
    localparam int HH_W    = HI_W + HI_W;
    localparam int CROSS_W = PP_W + 1;
    localparam int PROD_W  = 2 * DATA_W;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mulOp_e;

    // rs1 is treated as signed for MULH and MULHSU.
    function automatic logic signedA(input mulOp_e op);
        return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    endfunction

    // rs2 is treated as signed for MULH only.
    function automatic logic signedB(input mulOp_e op);
        return (op == MUL_OP_MULH);
    endfunction

endpackage

// File: rtl/mult_stage_reg.sv
// ---------------------------------------------------------------------------
// mult_stage_reg
// One pipeline slice of the multiplier: a valid bit plus the destination
// address, operation code and a stage-specific datapath payload.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   stall_i             : hold every field this cycle
//   valid_i/addr_i/op_i/data_i : contents offered by the previous stage
//   valid_o/addr_o/op_o/data_o : registered contents of this stage
// ---------------------------------------------------------------------------
module mult_stage_reg
    import mult_pipe_pkg::*;
#(
    parameter int DW = 1,
    parameter int AW = ADDR_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          stall_i,
    input  logic          valid_i,
    input  logic [AW-1:0] addr_i,
    input  mulOp_e        op_i,
    input  logic [DW-1:0] data_i,
    output logic          valid_o,
    output logic [AW-1:0] addr_o,
    output mulOp_e        op_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q, valid_d;
    logic [AW-1:0] addr_q,  addr_d;
    mulOp_e        op_q,    op_d;
    logic [DW-1:0] data_q,  data_d;

    // Next-state selection. A stall freezes the whole slice. When a bubble
    // arrives only the valid bit drops; the payload keeps the last live op so
    // the address and final result remain visible after it has moved on.
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        op_d    = op_q;
        data_d  = data_q;
        if (!stall_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                addr_d = addr_i;
                op_d   = op_i;
                data_d = data_i;
            end
        end
    end

    // Slice registers. Reset wins over stall and clears every field.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            op_q    <= MUL_OP_MUL;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            op_q    <= op_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign op_o    = op_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mult_pipe.sv
// ---------------------------------------------------------------------------
// mult_pipe
// Five-stage pipelined RV32M multiplier (MUL/MULH/MULHSU/MULHU). It publishes
// per-stage destination tags for the bypass controller and the final-stage
// result for forwarding and write-back.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   valid_i, op_i         : launch request and operation (00 MUL .. 11 MULHU)
//   src_a_i, src_b_i      : rs1 / rs2 values
//   dest_addr_i           : rd of the launching op
//   stall_i               : hold the entire pipeline
//   flush_i               : kill the op being launched this cycle
//   multN_addr_o          : stored rd of stage N (N = 1..5)
//   multN_wr_en_o         : stage N holds a live op with rd != x0
//   mult5_data_o          : result of the op in M5
//   busy_o                : any stage holds a live op
// Optional build macro MULT_PERF_CNT_EN adds perf_cnt_o, a 32-bit count of
// ops retiring from M5 (including those with rd = x0).
// ---------------------------------------------------------------------------
module mult_pipe #(
    parameter int DATA_W = mult_pipe_pkg::DATA_W,
    parameter int ADDR_W = mult_pipe_pkg::ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] src_a_i,
    input  logic [DATA_W-1:0] src_b_i,
    input  logic [ADDR_W-1:0] dest_addr_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [ADDR_W-1:0] mult1_addr_o,
    output logic [ADDR_W-1:0] mult2_addr_o,
    output logic [ADDR_W-1:0] mult3_addr_o,
    output logic [ADDR_W-1:0] mult4_addr_o,
    output logic [ADDR_W-1:0] mult5_addr_o,
    output logic              mult1_wr_en_o,
    output logic              mult2_wr_en_o,
    output logic              mult3_wr_en_o,
    output logic              mult4_wr_en_o,
    output logic              mult5_wr_en_o,
    output logic [DATA_W-1:0] mult5_data_o,
    output logic              busy_o
`ifdef MULT_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cnt_o
`endif
);

    import mult_pipe_pkg::*;

    localparam int M1_W = 2 * EXT_W;
    localparam int M2_W = HH_W + 3 * PP_W;
    localparam int M3_W = HH_W + CROSS_W + PP_W;

    logic [MULT_STAGES-1:0] stgValid;
    logic [ADDR_W-1:0]      stgAddr [MULT_STAGES];
    mulOp_e                 stgOp   [MULT_STAGES];

    logic [M1_W-1:0]   m1DataIn, m1Data;
    logic [M2_W-1:0]   m2DataIn, m2Data;
    logic [M3_W-1:0]   m3DataIn, m3Data;
    logic [PROD_W-1:0] m4DataIn, m4Data;
    logic [PROD_W-1:0] m5Data;

    mulOp_e launchOp;
    logic   launchValid;

    logic [EXT_W-1:0]        aExt, bExt, aQ, bQ;
    logic signed [LO_W:0]    aLoS, bLoS;
    logic signed [HI_W-1:0]  aHi, bHi;
    logic [PP_W-1:0]         ll;
    logic signed [PP_W-1:0]  lh, hl;
    logic signed [HH_W-1:0]  hh;
    logic [PP_W-1:0]         llQ;
    logic signed [PP_W-1:0]  lhQ, hlQ;
    logic signed [HH_W-1:0]  hhQ, hhR;
    logic signed [CROSS_W-1:0] crossSum, crossR;
    logic [PP_W-1:0]         llR;

    assign launchOp    = mulOp_e'(op_i);
    assign launchValid = valid_i && !flush_i;

    // M1 input: widen the operands to 33 bits with the sign rule of the op so
    // one signed product covers all four RV32M variants.
    always_comb begin
        aExt     = {signedA(launchOp) & src_a_i[DATA_W-1], src_a_i};
        bExt     = {signedB(launchOp) & src_b_i[DATA_W-1], src_b_i};
        m1DataIn = {aExt, bExt};
    end

    // M2 input: four partial products. Low halves are unsigned, so they get a
    // zero top bit before entering the signed cross products.
    always_comb begin
        aQ       = m1Data[M1_W-1:EXT_W];
        bQ       = m1Data[EXT_W-1:0];
        aLoS     = {1'b0, aQ[LO_W-1:0]};
        bLoS     = {1'b0, bQ[LO_W-1:0]};
        aHi      = aQ[EXT_W-1:LO_W];
        bHi      = bQ[EXT_W-1:LO_W];
        ll       = {{LO_W{1'b0}}, aQ[LO_W-1:0]} * {{LO_W{1'b0}}, bQ[LO_W-1:0]};
        lh       = PP_W'(aLoS) * PP_W'(bHi);
        hl       = PP_W'(aHi) * PP_W'(bLoS);
        hh       = HH_W'(aHi) * HH_W'(bHi);
        m2DataIn = {hh, hl, lh, ll};
    end

    // M3 input: fold the two cross terms together; both carry weight 2^17.
    always_comb begin
        llQ      = m2Data[PP_W-1:0];
        lhQ      = m2Data[2*PP_W-1:PP_W];
        hlQ      = m2Data[3*PP_W-1:2*PP_W];
        hhQ      = m2Data[M2_W-1:3*PP_W];
        crossSum = CROSS_W'(lhQ) + CROSS_W'(hlQ);
        m3DataIn = {hhQ, crossSum, llQ};
    end

    // M4 input: final weighted sum. Only the low 64 bits of the 66-bit signed
    // product are ever selected, so the sum is formed modulo 2^64.
    always_comb begin
        llR      = m3Data[PP_W-1:0];
        crossR   = m3Data[PP_W+CROSS_W-1:PP_W];
        hhR      = m3Data[M3_W-1:PP_W+CROSS_W];
        m4DataIn = (PROD_W'(hhR) << (2 * LO_W))
                 + (PROD_W'(crossR) << LO_W)
                 + PROD_W'(llR);
    end

    mult_stage_reg #(.DW(M1_W), .AW(ADDR_W)) u_stage1 (
        .clk_i   (clk_i),       .rst_i  (rst_i),       .stall_i (stall_i),
        .valid_i (launchValid), .addr_i (dest_addr_i), .op_i    (launchOp),
        .data_i  (m1DataIn),
        .valid_o (stgValid[0]), .addr_o (stgAddr[0]),  .op_o    (stgOp[0]),
        .data_o  (m1Data)
    );

    mult_stage_reg #(.DW(M2_W), .AW(ADDR_W)) u_stage2 (
        .clk_i   (clk_i),       .rst_i  (rst_i),       .stall_i (stall_i),
        .valid_i (stgValid[0]), .addr_i (stgAddr[0]),  .op_i    (stgOp[0]),
        .data_i  (m2DataIn),
        .valid_o (stgValid[1]), .addr_o (stgAddr[1]),  .op_o    (stgOp[1]),
        .data_o  (m2Data)
    );

    mult_stage_reg #(.DW(M3_W), .AW(ADDR_W)) u_stage3 (
        .clk_i   (clk_i),       .rst_i  (rst_i),       .stall_i (stall_i),
        .valid_i (stgValid[1]), .addr_i (stgAddr[1]),  .op_i    (stgOp[1]),
        .data_i  (m3DataIn),
        .valid_o (stgValid[2]), .addr_o (stgAddr[2]),  .op_o    (stgOp[2]),
        .data_o  (m3Data)
    );

    mult_stage_reg #(.DW(PROD_W), .AW(ADDR_W)) u_stage4 (
        .clk_i   (clk_i),       .rst_i  (rst_i),       .stall_i (stall_i),
        .valid_i (stgValid[2]), .addr_i (stgAddr[2]),  .op_i    (stgOp[2]),
        .data_i  (m4DataIn),
        .valid_o (stgValid[3]), .addr_o (stgAddr[3]),  .op_o    (stgOp[3]),
        .data_o  (m4Data)
    );

    mult_stage_reg #(.DW(PROD_W), .AW(ADDR_W)) u_stage5 (
        .clk_i   (clk_i),       .rst_i  (rst_i),       .stall_i (stall_i),
        .valid_i (stgValid[3]), .addr_i (stgAddr[3]),  .op_i    (stgOp[3]),
        .data_i  (m4Data),
        .valid_o (stgValid[4]), .addr_o (stgAddr[4]),  .op_o    (stgOp[4]),
        .data_o  (m5Data)
    );

    // Result select: MUL returns the low word, every high variant the upper
    // word. M5 keeps its payload while empty, so this holds the last result.
    always_comb begin
        mult5_data_o = (stgOp[4] == MUL_OP_MUL) ? m5Data[DATA_W-1:0]
                                                : m5Data[PROD_W-1:DATA_W];
    end

    // Tags for the bypass controller: an op writing x0 never creates a hazard.
    always_comb begin
        mult1_addr_o  = stgAddr[0];
        mult2_addr_o  = stgAddr[1];
        mult3_addr_o  = stgAddr[2];
        mult4_addr_o  = stgAddr[3];
        mult5_addr_o  = stgAddr[4];
        mult1_wr_en_o = stgValid[0] && (stgAddr[0] != '0);
        mult2_wr_en_o = stgValid[1] && (stgAddr[1] != '0);
        mult3_wr_en_o = stgValid[2] && (stgAddr[2] != '0);
        mult4_wr_en_o = stgValid[3] && (stgAddr[3] != '0);
        mult5_wr_en_o = stgValid[4] && (stgAddr[4] != '0);
        busy_o        = |stgValid;
    end

`ifdef MULT_PERF_CNT_EN
    logic [31:0] perfCnt_q, perfCnt_d;

    // Retirement counter: an op retires when M5 is live and the pipe advances.
    always_comb begin
        perfCnt_d = perfCnt_q;
        if (!stall_i && stgValid[4]) begin
            perfCnt_d = perfCnt_q + 32'd1;
        end
    end

    // Counter register, cleared by reset and free to wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perfCnt_q <= '0;
        end else begin
            perfCnt_q <= perfCnt_d;
        end
    end

    assign perf_cnt_o = perfCnt_q;
`endif

endmodule

// File: tb/tb_mult_pipe.sv
// ---------------------------------------------------------------------------
// tb_mult_pipe
// Directed, self-checking bench for mult_pipe. Inputs change 1 time unit
// after each rising edge and outputs are checked there as well.
// ---------------------------------------------------------------------------
module tb_mult_pipe;

    import mult_pipe_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [1:0]  op_i;
    logic [31:0] src_a_i;
    logic [31:0] src_b_i;
    logic [4:0]  dest_addr_i;
    logic        stall_i;
    logic        flush_i;
    logic [4:0]  mult1_addr_o, mult2_addr_o, mult3_addr_o, mult4_addr_o, mult5_addr_o;
    logic        mult1_wr_en_o, mult2_wr_en_o, mult3_wr_en_o, mult4_wr_en_o, mult5_wr_en_o;
    logic [31:0] mult5_data_o;
    logic        busy_o;
`ifdef MULT_PERF_CNT_EN
    logic [31:0] perf_cnt_o;
`endif

    logic [4:0]  wrVec;
    int          testCount = 0;
    int          failCount = 0;

    mulOp_e      vOp  [5] = '{MUL_OP_MULH, MUL_OP_MULHU, MUL_OP_MULHSU, MUL_OP_MUL, MUL_OP_MULH};
    logic [31:0] vA   [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
    logic [31:0] vB   [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] vExp [5] = '{32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h80000000, 32'h40000000};

    mult_pipe dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .valid_i       (valid_i),
        .op_i          (op_i),
        .src_a_i       (src_a_i),
        .src_b_i       (src_b_i),
        .dest_addr_i   (dest_addr_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .mult1_addr_o  (mult1_addr_o),
        .mult2_addr_o  (mult2_addr_o),
        .mult3_addr_o  (mult3_addr_o),
        .mult4_addr_o  (mult4_addr_o),
        .mult5_addr_o  (mult5_addr_o),
        .mult1_wr_en_o (mult1_wr_en_o),
        .mult2_wr_en_o (mult2_wr_en_o),
        .mult3_wr_en_o (mult3_wr_en_o),
        .mult4_wr_en_o (mult4_wr_en_o),
        .mult5_wr_en_o (mult5_wr_en_o),
        .mult5_data_o  (mult5_data_o),
        .busy_o        (busy_o)
`ifdef MULT_PERF_CNT_EN
        ,
        .perf_cnt_o    (perf_cnt_o)
`endif
    );

    // Free-running clock, period 10.
    always #5 clk_i = ~clk_i;

    // Write-enable tags packed as {M5..M1} for compact checks.
    assign wrVec = {mult5_wr_en_o, mult4_wr_en_o, mult3_wr_en_o, mult2_wr_en_o, mult1_wr_en_o};

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive one cycle worth of request inputs.
    task automatic applyStimulus(input logic v, input logic [1:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input logic st, input logic fl);
        valid_i     = v;
        op_i        = op;
        src_a_i     = a;
        src_b_i     = b;
        dest_addr_i = rd;
        stall_i     = st;
        flush_i     = fl;
    endtask

    // Compare one observed value with its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Idle cycle: no launch, no stall, no flush.
    task automatic idle();
        applyStimulus(1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
    endtask

    // Directed sequence.
    initial begin
        rst_i = 1'b1;
        idle();
        tick();
        tick();
        rst_i = 1'b0;

        // Reset state
        checkOutput("reset_wr", 32'(wrVec), 32'h0);
        checkOutput("reset_busy", 32'(busy_o), 32'h0);
        checkOutput("reset_data", mult5_data_o, 32'h0);
        checkOutput("reset_addr1", 32'(mult1_addr_o), 32'h0);
`ifdef MULT_PERF_CNT_EN
        checkOutput("reset_perf", perf_cnt_o, 32'h0);
`endif

        // MUL 7*6 rd=3: M1 after one edge, M5 four edges later
        applyStimulus(1'b1, MUL_OP_MUL, 32'd7, 32'd6, 5'd3, 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("mul1_wr", 32'(wrVec), 32'h01);
        checkOutput("mul1_addr1", 32'(mult1_addr_o), 32'd3);
        checkOutput("mul1_busy", 32'(busy_o), 32'h1);
        tick(); tick(); tick();
        checkOutput("mul1_m4_wr", 32'(wrVec), 32'h08);
        tick();
        checkOutput("mul1_m5_wr", 32'(wrVec), 32'h10);
        checkOutput("mul1_m5_addr", 32'(mult5_addr_o), 32'd3);
        checkOutput("mul1_m5_data", mult5_data_o, 32'h0000002A);
        tick();
        checkOutput("mul1_drain_busy", 32'(busy_o), 32'h0);

        // Five back-to-back launches rd=1..5 with corner-case operands
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, vOp[i], vA[i], vB[i], 5'(i + 1), 1'b0, 1'b0);
            tick();
        end
        idle();
        checkOutput("b2b_wr", 32'(wrVec), 32'h1F);
        checkOutput("b2b_busy", 32'(busy_o), 32'h1);
        checkOutput("b2b_addr1", 32'(mult1_addr_o), 32'd5);
        checkOutput("b2b_addr2", 32'(mult2_addr_o), 32'd4);
        checkOutput("b2b_addr3", 32'(mult3_addr_o), 32'd3);
        checkOutput("b2b_addr4", 32'(mult4_addr_o), 32'd2);
        checkOutput("b2b_addr5", 32'(mult5_addr_o), 32'd1);
        checkOutput("b2b_data0", mult5_data_o, vExp[0]);
        for (int i = 1; i < 5; i++) begin
            tick();
            checkOutput($sformatf("b2b_wr5_%0d", i), 32'(mult5_wr_en_o), 32'h1);
            checkOutput($sformatf("b2b_addr5_%0d", i), 32'(mult5_addr_o), 32'(i + 1));
            checkOutput($sformatf("b2b_data%0d", i), mult5_data_o, vExp[i]);
        end
        tick();
        checkOutput("b2b_drain_busy", 32'(busy_o), 32'h0);
`ifdef MULT_PERF_CNT_EN
        checkOutput("b2b_perf", perf_cnt_o, 32'd6);
`endif

        // Stall with M2 and M4 occupied
        applyStimulus(1'b1, MUL_OP_MUL, 32'd3, 32'd5, 5'd7, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        applyStimulus(1'b1, MUL_OP_MULHU, 32'h00010000, 32'h00010000, 5'd9, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        checkOutput("pre_stall_wr", 32'(wrVec), 32'h0A);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, MUL_OP_MUL, 32'd2, 32'd2, 5'd12, 1'b1, 1'b0);
            tick();
            checkOutput($sformatf("stall_wr_%0d", i), 32'(wrVec), 32'h0A);
            checkOutput($sformatf("stall_addr4_%0d", i), 32'(mult4_addr_o), 32'd7);
            checkOutput($sformatf("stall_addr2_%0d", i), 32'(mult2_addr_o), 32'd9);
        end
        idle();
        tick();
        checkOutput("resume_wr_a", 32'(wrVec), 32'h14);
        checkOutput("resume_data_a", mult5_data_o, 32'd15);
        checkOutput("resume_addr_a", 32'(mult5_addr_o), 32'd7);
        tick();
        checkOutput("resume_wr_mid", 32'(wrVec), 32'h08);
        tick();
        checkOutput("resume_wr_b", 32'(wrVec), 32'h10);
        checkOutput("resume_data_b", mult5_data_o, 32'h00000001);
        checkOutput("resume_addr_b", 32'(mult5_addr_o), 32'd9);
        tick();
        checkOutput("stall_drain_busy", 32'(busy_o), 32'h0);
`ifdef MULT_PERF_CNT_EN
        checkOutput("stall_perf", perf_cnt_o, 32'd8);
`endif

        // Flush of the launching op while an older op sits in M3
        applyStimulus(1'b1, MUL_OP_MUL, 32'h12345678, 32'h00000010, 5'd10, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        applyStimulus(1'b1, MUL_OP_MUL, 32'd4, 32'd4, 5'd11, 1'b0, 1'b1);
        tick();
        idle();
        checkOutput("flush_wr", 32'(wrVec), 32'h04);
        tick();
        tick();
        checkOutput("flush_m5_wr", 32'(wrVec), 32'h10);
        checkOutput("flush_m5_data", mult5_data_o, 32'h23456780);
        checkOutput("flush_m5_addr", 32'(mult5_addr_o), 32'd10);
        tick();
        checkOutput("flush_drain_busy", 32'(busy_o), 32'h0);

        // rd = x0: flows through, never raises a write enable
        applyStimulus(1'b1, MUL_OP_MUL, 32'd9, 32'd9, 5'd0, 1'b0, 1'b0);
        tick();
        idle();
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("x0_wr_%0d", i), 32'(wrVec), 32'h0);
            checkOutput($sformatf("x0_busy_%0d", i), 32'(busy_o), 32'h1);
            tick();
        end
        checkOutput("x0_drain_busy", 32'(busy_o), 32'h0);
`ifdef MULT_PERF_CNT_EN
        checkOutput("x0_perf", perf_cnt_o, 32'd10);
`endif

        // Reset with three ops in flight: nothing retires afterwards
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, MUL_OP_MUL, 32'd1, 32'd1, 5'(i + 1), 1'b0, 1'b0);
            tick();
        end
        checkOutput("pre_rst_wr", 32'(wrVec), 32'h07);
        rst_i = 1'b1;
        applyStimulus(1'b1, MUL_OP_MUL, 32'd1, 32'd1, 5'd6, 1'b1, 1'b1);
        tick();
        rst_i = 1'b0;
        idle();
        checkOutput("rst_wr", 32'(wrVec), 32'h0);
        checkOutput("rst_busy", 32'(busy_o), 32'h0);
        checkOutput("rst_data", mult5_data_o, 32'h0);
`ifdef MULT_PERF_CNT_EN
        checkOutput("rst_perf", perf_cnt_o, 32'h0);
`endif
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("post_rst_wr_%0d", i), 32'(wrVec), 32'h0);
            checkOutput($sformatf("post_rst_busy_%0d", i), 32'(busy_o), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/mult_pipe.md
Name: mult_pipe

Overview:
- Five-stage pipelined integer multiplier (RV32M MUL/MULH/MULHSU/MULHU); the producer side of the bypass network.
- Launches ops from the execute stage, tracks each in-flight destination per stage, and publishes per-stage address/write-enable tags plus final-stage data.
- The bypass controller consumes these tags to forward M5 data or stall on M1–M4 hazards; the write-back mux also takes M5 results.

Parameters:
- DATA_W, 32, operand/result width (only 32 supported)
- ADDR_W, 5, register address width

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  synchronous reset, active-high
- valid_i  in  1  launch a multiply this cycle
- op_i  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- src_a_i  in  DATA_W  rs1 value
- src_b_i  in  DATA_W  rs2 value
- dest_addr_i  in  ADDR_W  rd
- stall_i  in  1  hold entire pipeline
- flush_i  in  1  kill the op being launched this cycle
- multN_addr_o  out  ADDR_W  dest of stage N, N=1..5 (five ports)
- multN_wr_en_o  out  1  stage N holds a live op with rd!=0, N=1..5 (five ports)
- mult5_data_o  out  DATA_W  result, meaningful only when mult5_wr_en_o=1
- busy_o  out  1  OR of all stage valid bits

Behaviour:
- Reset: clk_i and rst_i only; reset is synchronous, active-high. On rst_i at a rising edge, all stage valid bits, multN_addr_o, multN_wr_en_o, mult5_data_o and busy_o become 0. Reset has priority over stall_i and flush_i. Reset mid-operation drops all in-flight ops with no result.
- Internal per-stage state: valid, addr, op, datapath registers.
- Launch: on an edge with valid_i=1, stall_i=0, flush_i=0, the op enters M1.
- Latency: op sampled at edge k is visible on mult1_* after edge k, and on mult5_* after edge k+4. Throughput: 1 op/cycle.
- Advance: when stall_i=0, every stage Mn+1 takes Mn (n=1..4). M5 takes M4, and the old M5 retires; no acknowledge is needed.
  - If valid_i=0 or flush_i=1, M1 loads a bubble (valid=0).
- Stall: when stall_i=1 and rst_i=0, all stage registers hold and valid_i is ignored. Upstream re-presents the op.
- Flush: affects only the launching op; ops already in M1–M5 are committed and continue. flush_i=1 with stall_i=1: hold, and flush_i is ignored.
- multN_wr_en_o = valid_N AND (addr_N != 0). An op with rd=x0 flows through but never asserts wr_en. multN_addr_o shows the stored addr even when invalid.
- Arithmetic: extend each operand to 33 bits.
  - a is signed for MULH/MULHSU.
  - b is signed for MULH only.
  - Otherwise operands are zero-extended.
- Form the exact 66-bit signed product across M1–M4 (recommended: M1 register operands, M2 four 17x17 partial products, M3 cross-term sum, M4 final sum).
- In M5, select product[31:0] for MUL or product[63:32] for the others. Results must be bit-exact to the RV32M definition.
- mult5_data_o holds its last value while M5 is invalid. Verification checks it only when mult5_wr_en_o=1.

Optional Feature:
- MULT_PERF_CNT_EN
  - Defined: adds output perf_cnt_o (32 bits), the count of ops retiring from a valid M5 (including rd=x0). Increments on edges with stall_i=0. Cleared by rst_i; wraps 0xFFFFFFFF->0.
  - Undefined: port and counter are absent.

Decomposition:
- Shared package: op encodings (MUL_OP_MUL/MULH/MULHSU/MULHU), DATA_W/ADDR_W constants, MULT_STAGES=5.
- One natural sub-module, mult_stage_reg: a valid/addr/op/data register slice with stall hold and bubble insert, instantiated per stage.
- The datapath stays inline.

Test Plan:
- Launch MUL 7*6 rd=3 -> mult1_wr_en_o=1, mult1_addr_o=3 after next edge; mult5_data_o=0x0000002A, mult5_wr_en_o=1 exactly 4 edges later.
- MULH 0xFFFFFFFF*0xFFFFFFFF -> 0x00000000; MULHU same operands -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF; MUL 0x80000000*0xFFFFFFFF -> 0x80000000.
- Back-to-back 5 launches rd=1..5 -> mult1..mult5_addr_o = 5,4,3,2,1 simultaneously, all wr_en=1, busy_o=1; results retire on consecutive cycles.
- stall_i high 3 cycles with M2 and M4 occupied -> all tags/data frozen; valid_i during the stall is not captured; pipeline resumes unchanged.
- flush_i with valid_i=1 and an op in M3 -> M1 bubble (mult1_wr_en_o=0); the M3 op still retires correctly. Launch rd=0 -> all multN_wr_en_o stay 0 while busy_o=1.
- rst_i asserted with 3 ops in flight -> next edge all wr_en=0, busy_o=0, perf_cnt_o=0 (if enabled); no late retirement.
